// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide engine.
// Build option: MULTDIV_FAST_DIV0_EN short-cuts divide-by-zero straight to DONE.
package multdiv_pkg;
  localparam int MD_WIDTH   = 32;
  localparam int MD_CNT_W   = $clog2(MD_WIDTH);
  localparam int MD_LATENCY = MD_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;
endpackage

// File: rtl/multdiv_abs.sv
// Two's-complement conditional negate; with neg_en tied to the sign bit it
// yields the absolute value (0x80..0 maps to its unsigned magnitude).
module multdiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg_en,
  output logic [W-1:0] out_val
);
  assign out_val = neg_en ? (~in_val + W'(1)) : in_val;
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per cycle.
// Build option: MULTDIV_FAST_DIV0_EN sends a DIV start with divisor 0 directly to DONE.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;

  logic               start_mult, start_div;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mult_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     prod_top;
  logic               res_neg, unused_bits;

  assign start_mult = ctrl_MULT & ~ctrl_DIV;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;
  assign res_neg    = sign_a_q ^ sign_b_q;

  multdiv_abs #(.W(WIDTH)) u_abs_a (
    .in_val(data_operandA), .neg_en(data_operandA[WIDTH-1]), .out_val(a_abs));
  multdiv_abs #(.W(WIDTH)) u_abs_b (
    .in_val(data_operandB), .neg_en(data_operandB[WIDTH-1]), .out_val(b_abs));
  multdiv_abs #(.W(2*WIDTH)) u_fix_prod (
    .in_val(prod_q), .neg_en(res_neg), .out_val(prod_fix));
  multdiv_abs #(.W(WIDTH)) u_fix_quo (
    .in_val(quo_q), .neg_en(res_neg), .out_val(quo_fix));

  // One multiply step: conditionally add the multiplicand into the upper half, then shift right.
  assign mult_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
  // One restoring-divide step: bring in the next dividend bit and trial-subtract the divisor.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
  assign prod_top  = prod_fix[2*WIDTH-1:WIDTH-1];
  assign unused_bits = ^{div_diff[WIDTH], div_shift[WIDTH]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (start_mult || start_div) begin
      a_mag_d  = a_abs;
      b_mag_d  = b_abs;
      sign_a_d = data_operandA[WIDTH-1];
      sign_b_d = data_operandB[WIDTH-1];
      is_div_d = start_div;
      cnt_d    = '0;
      prod_d   = {{WIDTH{1'b0}}, b_abs};
      rem_d    = '0;
      quo_d    = a_abs;
      busy_d   = 1'b1;
      state_d  = start_div ? DIV : MULT;
`ifdef MULTDIV_FAST_DIV0_EN
      if (start_div && (data_operandB == '0)) state_d = DONE;
`endif
    end else begin
      case (state_q)
        MULT: begin
          prod_d = {mult_sum, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
        end
        DIV: begin
          if (!div_diff[WIDTH+1]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
        end
        DONE: begin
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!is_div_q) begin
            result_d = prod_fix[WIDTH-1:0];
            exc_d    = !((&prod_top) || !(|prod_top));
          end else if (b_mag_q == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo_fix;
            // Only MIN / -1 yields a positive quotient with the top bit set.
            exc_d    = !res_neg && quo_q[WIDTH-1];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expectations queued at each start, popped on RDY.
// Honours MULTDIV_FAST_DIV0_EN for the expected divide-by-zero latency.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  multdiv_unit #(.WIDTH(MD_WIDTH)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy));

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic void model(bit is_div, logic [31:0] a, logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (!is_div) begin
      p  = longint'(sa) * longint'(sb);
      pu = p;
      r  = pu[31:0];
      e  = !((pu[63:31] == '0) || (pu[63:31] == {33{1'b1}}));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = 32'(sa / sb);
      e = 1'b0;
    end
  endfunction

  // Inputs change 2 time units after each rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic purge();
    while (q.size() > 0 && q[$].due > edge_cnt) void'(q.pop_back());
  endtask

  task automatic issue(bit is_div, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   s;
    s = edge_cnt + 1;
    purge();
    model(is_div, a, b, e.res, e.exc);
    e.due = s + MD_LATENCY;
`ifdef MULTDIV_FAST_DIV0_EN
    if (is_div && b == 32'd0) e.due = s + 1;
`endif
    q.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV  = is_div;
    ctrl_MULT = !is_div;
    tick();
    ctrl_DIV  = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      check("rdy_timeout", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  always @(negedge clock) begin
    if (reset && data_resultRDY) begin
      if (q.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn edge=%0d result=%h exc=%0b (exp %h/%0b due %0d)",
                 edge_cnt, data_result, data_exception, e.res, e.exc, e.due);
        check("rdy_edge", 32'(edge_cnt), 32'(e.due));
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("busy_in_rdy", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] er;
    logic        ee;
    int          n;
    int          s;

    repeat (3) tick();
    reset = 1'b1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    check("busy_running", {31'd0, busy}, 32'd1);
    drain();
    issue(1'b0, 32'h0001_0000, 32'h0001_0000); drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);         drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); drain();
    issue(1'b1, 32'd5, 32'd0);                 drain();
    issue(1'b0, 32'h8000_0000, 32'd1);         drain();

    // Simultaneous starts must be ignored entirely.
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) tick();

    // New start accepted in the RDY cycle; the earlier result stays until its own DONE.
    issue(1'b0, 32'd12345, 32'hFFFF_FD5A);
    n = 0;
    while (!data_resultRDY && n < 100) begin
      tick();
      n++;
    end
    check("rdy_seen", {31'd0, data_resultRDY}, 32'd1);
    model(1'b0, 32'd12345, 32'hFFFF_FD5A, er, ee);
    issue(1'b1, 32'd1000, 32'hFFFF_FFF9);
    check("rdy_falls", {31'd0, data_resultRDY}, 32'd0);
    check("held_mid_op", data_result, er);
    drain();
    model(1'b1, 32'd1000, 32'hFFFF_FFF9, er, ee);
    repeat (5) tick();
    check("hold_result", data_result, er);

    // Abort: MULT at S, DIV at S+10, only the DIV completes.
    issue(1'b0, 32'd3, 32'd4);
    repeat (9) tick();
    issue(1'b1, 32'd100, 32'd10);
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(0, 40) - 20;
      issue(i[0], ra, rb);
      drain();
    end

    // Reset asserted for one edge in the middle of a MULT.
    issue(1'b0, 32'd9, 32'd11);
    s = edge_cnt;
    repeat (4) tick();
    reset = 1'b0;
    purge();
    tick();
    reset = 1'b1;
    check("rst_mid_edge", 32'(edge_cnt), 32'(s + 5));
    check("rst_mid_result", data_result, 32'd0);
    check("rst_mid_exc", {31'd0, data_exception}, 32'd0);
    check("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    while (edge_cnt < s + 40) tick();
    issue(1'b0, 32'hFFFF_FFF0, 32'd6);
    drain();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
